// File: rtl/spmv_kernel_scheduler.sv
// SpMV kernel scheduler: per-kernel start/clear edge detection, parameter
// validation, row/nnz latching, round-robin launch arbitration with a cap on
// concurrently running kernels, done/timeout tracking and status readback.

// Per-kernel lane: edge detect, IDLE/PEND/RUN FSM, latched params, status.
module spmv_kernel_lane #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FFFFFF
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] ctrl,
  input  logic [31:0] row,
  input  logic [31:0] nnz,
  input  logic        grant,
  input  logic        done_in,
  output logic        pend,
  output logic        run,
  output logic        start,
  output logic [31:0] row_num,
  output logic [31:0] nnz_num,
  output logic [31:0] status
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ctrl_prev_q, ctrl_prev_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        err_param_q, err_param_d;
  logic        err_timeout_q, err_timeout_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] row_q, row_d;
  logic [31:0] nnz_q, nnz_d;

  logic        start_rise, clear_rise;
  logic [23:0] cnt_inc;
  logic        unused_ctrl;

  // only the start and clear bits of the ctrl word carry meaning
  assign unused_ctrl = ^ctrl[31:2];

  assign start_rise = ctrl[0] & ~ctrl_prev_q[0];
  assign clear_rise = ctrl[1] & ~ctrl_prev_q[1];
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 24'd1;

  // next-state: rises only act in IDLE; done in the start cycle is ignored
  always_comb begin
    state_d       = state_q;
    ctrl_prev_d   = ctrl[1:0];
    start_d       = 1'b0;
    done_d        = done_q;
    err_param_d   = err_param_q;
    err_timeout_d = err_timeout_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    nnz_d         = nnz_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          if (row != '0 && nnz != '0) begin
            state_d       = ST_PEND;
            row_d         = row;
            nnz_d         = nnz;
            done_d        = 1'b0;
            err_param_d   = 1'b0;
            err_timeout_d = 1'b0;
            cnt_d         = '0;
          end else begin
            err_param_d = 1'b1;
            done_d      = 1'b0;
          end
        end else if (clear_rise) begin
          done_d        = 1'b0;
          err_param_d   = 1'b0;
          err_timeout_d = 1'b0;
          cnt_d         = '0;
        end
      end
      ST_PEND: begin
        if (grant) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (done_in && !start_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if ({8'd0, cnt_inc} >= TIMEOUT_CYCLES) begin
            state_d       = ST_IDLE;
            done_d        = 1'b1;
            err_timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // lane registers; ctrl history resets high so a held level never retriggers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      ctrl_prev_q   <= 2'b11;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      err_param_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
      row_q         <= '0;
      nnz_q         <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_prev_q   <= ctrl_prev_d;
      start_q       <= start_d;
      done_q        <= done_d;
      err_param_q   <= err_param_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      nnz_q         <= nnz_d;
    end
  end

  assign pend    = (state_q == ST_PEND);
  assign run     = (state_q == ST_RUN);
  assign start   = start_q;
  assign row_num = row_q;
  assign nnz_num = nnz_q;
  assign status  = {cnt_q, 3'b000, err_timeout_q, err_param_q, done_q, run, pend};

endmodule

// Top: lane array plus round-robin launch arbiter.
module spmv_kernel_scheduler #(
  parameter int          NUM_KERNEL     = 4,
  parameter int          MAX_ACTIVE     = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FFFFFF
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [96*NUM_KERNEL-1:0] config_wire,
  output logic [NUM_KERNEL-1:0]   kernel_start,
  output logic [32*NUM_KERNEL-1:0] kernel_row_num,
  output logic [32*NUM_KERNEL-1:0] kernel_nnz_num,
  input  logic [NUM_KERNEL-1:0]   kernel_done,
  output logic [32*NUM_KERNEL-1:0] kernel_status
);

  localparam int IDX_W = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1;

  logic [NUM_KERNEL-1:0] pend, run, grant;
  logic [IDX_W-1:0]      rr_q, rr_d;
  int                    run_cnt;
  logic                  found;
  logic [IDX_W-1:0]      idx;

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    spmv_kernel_lane #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_lane (
      .aclk    (aclk),
      .areset  (areset),
      .ctrl    (config_wire[96*k      +: 32]),
      .row     (config_wire[96*k + 32 +: 32]),
      .nnz     (config_wire[96*k + 64 +: 32]),
      .grant   (grant[k]),
      .done_in (kernel_done[k]),
      .pend    (pend[k]),
      .run     (run[k]),
      .start   (kernel_start[k]),
      .row_num (kernel_row_num[32*k +: 32]),
      .nnz_num (kernel_nnz_num[32*k +: 32]),
      .status  (kernel_status[32*k +: 32])
    );
  end

  // one grant per cycle, gated by the pre-edge RUN population; search from rr_q
  always_comb begin
    run_cnt = 0;
    for (int k = 0; k < NUM_KERNEL; k++) run_cnt = run_cnt + int'(run[k]);
    grant = '0;
    rr_d  = rr_q;
    found = 1'b0;
    idx   = '0;
    if (run_cnt < MAX_ACTIVE) begin
      for (int off = 0; off < NUM_KERNEL; off++) begin
        idx = IDX_W'((int'(rr_q) + off) % NUM_KERNEL);
        if (!found && pend[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          rr_d       = IDX_W'((int'(idx) + 1) % NUM_KERNEL);
        end
      end
    end
  end

  // round-robin pointer
  always_ff @(posedge aclk) begin
    if (areset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  a_run_cap: assert property (@(posedge aclk) disable iff (areset) run_cnt <= MAX_ACTIVE);

endmodule

// File: tb/tb_spmv_kernel_scheduler.sv
// Bench: two scheduler instances (MAX_ACTIVE 2/TIMEOUT 16 and MAX_ACTIVE 1/
// TIMEOUT 40) share one stimulus; each is compared every cycle against a
// behavioural model, with directed spot checks of the documented scenarios.
module tb_spmv_kernel_scheduler;
  localparam int NK = 4;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic [96*NK-1:0]   cfg = '0;
  logic [NK-1:0]      kdone = '0;
  logic [NK-1:0]      ks0, ks1;
  logic [32*NK-1:0]   row0, row1, nnz0, nnz1, st0, st1;

  always #5 aclk = ~aclk;

  spmv_kernel_scheduler #(.NUM_KERNEL(NK), .MAX_ACTIVE(2), .TIMEOUT_CYCLES(32'd16)) u_dut0 (
    .aclk(aclk), .areset(areset), .config_wire(cfg), .kernel_start(ks0),
    .kernel_row_num(row0), .kernel_nnz_num(nnz0), .kernel_done(kdone), .kernel_status(st0));

  spmv_kernel_scheduler #(.NUM_KERNEL(NK), .MAX_ACTIVE(1), .TIMEOUT_CYCLES(32'd40)) u_dut1 (
    .aclk(aclk), .areset(areset), .config_wire(cfg), .kernel_start(ks1),
    .kernel_row_num(row1), .kernel_nnz_num(nnz1), .kernel_done(kdone), .kernel_status(st1));

  int n_chk = 0, n_fail = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // behavioural model state, [instance][kernel]
  int          maxa[2] = '{2, 1};
  int unsigned tmo[2]  = '{16, 40};
  bit          m_pend[2][NK], m_run[2][NK], m_first[2][NK];
  bit          m_dn[2][NK], m_ep[2][NK], m_et[2][NK];
  int unsigned m_cnt[2][NK];
  logic [31:0] m_row[2][NK], m_nnz[2][NK];
  logic [1:0]  m_prev[2][NK];
  int          m_rr[2];

  task automatic model_tick(input int d);
    int nrun, g, kk;
    logic [31:0] c, r, n;
    bit sr, cr, wf;
    if (areset) begin
      for (int k = 0; k < NK; k++) begin
        m_pend[d][k] = 0; m_run[d][k] = 0; m_first[d][k] = 0;
        m_dn[d][k] = 0; m_ep[d][k] = 0; m_et[d][k] = 0; m_cnt[d][k] = 0;
        m_row[d][k] = '0; m_nnz[d][k] = '0; m_prev[d][k] = 2'b11;
      end
      m_rr[d] = 0;
    end else begin
      nrun = 0;
      for (int k = 0; k < NK; k++) nrun += int'(m_run[d][k]);
      g = -1;
      if (nrun < maxa[d])
        for (int o = 0; o < NK; o++) begin
          kk = (m_rr[d] + o) % NK;
          if (g < 0 && m_pend[d][kk]) g = kk;
        end
      for (int k = 0; k < NK; k++) begin
        c  = cfg[96*k +: 32];
        r  = cfg[96*k + 32 +: 32];
        n  = cfg[96*k + 64 +: 32];
        sr = c[0] && !m_prev[d][k][0];
        cr = c[1] && !m_prev[d][k][1];
        wf = m_first[d][k];
        m_first[d][k] = 0;
        if (m_run[d][k]) begin
          if (kdone[k] && !wf) begin
            m_run[d][k] = 0; m_dn[d][k] = 1;
          end else begin
            if (m_cnt[d][k] < 32'hFFFFFF) m_cnt[d][k]++;
            if (m_cnt[d][k] >= tmo[d]) begin
              m_run[d][k] = 0; m_dn[d][k] = 1; m_et[d][k] = 1;
            end
          end
        end else if (m_pend[d][k]) begin
          if (g == k) begin m_pend[d][k] = 0; m_run[d][k] = 1; m_first[d][k] = 1; end
        end else if (sr) begin
          if (r != 0 && n != 0) begin
            m_pend[d][k] = 1; m_row[d][k] = r; m_nnz[d][k] = n;
            m_dn[d][k] = 0; m_ep[d][k] = 0; m_et[d][k] = 0; m_cnt[d][k] = 0;
          end else begin
            m_ep[d][k] = 1; m_dn[d][k] = 0;
          end
        end else if (cr) begin
          m_dn[d][k] = 0; m_ep[d][k] = 0; m_et[d][k] = 0; m_cnt[d][k] = 0;
        end
        m_prev[d][k] = c[1:0];
      end
      if (g >= 0) m_rr[d] = (g + 1) % NK;
    end
  endtask

  task automatic check_outputs();
    logic [NK-1:0]    es;
    logic [32*NK-1:0] er, en, est;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NK; k++) begin
        es[k] = m_first[d][k];
        er[32*k +: 32]  = m_row[d][k];
        en[32*k +: 32]  = m_nnz[d][k];
        est[32*k +: 32] = {24'(m_cnt[d][k]), 3'b000, m_et[d][k], m_ep[d][k],
                           m_dn[d][k], m_run[d][k], m_pend[d][k]};
      end
      chk($sformatf("%s i%0d start", phase, d), (d == 0) ? ks0 : ks1, es);
      chk($sformatf("%s i%0d row", phase, d), (d == 0) ? row0 : row1, er);
      chk($sformatf("%s i%0d nnz", phase, d), (d == 0) ? nnz0 : nnz1, en);
      chk($sformatf("%s i%0d status", phase, d), (d == 0) ? st0 : st1, est);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_tick(0);
    model_tick(1);
    @(negedge aclk);
    check_outputs();
  endtask

  task automatic set_k(input int k, input logic [31:0] c, input logic [31:0] r, input logic [31:0] n);
    cfg[96*k +: 32]      = c;
    cfg[96*k + 32 +: 32] = r;
    cfg[96*k + 64 +: 32] = n;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    kdone  = '0;
    step();
    step();
    areset = 1'b0;
  endtask

  int          grants[$];
  logic [31:0] c;

  initial begin
    @(negedge aclk);

    // 1: basic launch and completion
    phase = "t1";
    do_reset();
    chk("t1 reset status", st0, '0);
    chk("t1 reset start", ks0, '0);
    set_k(0, 0, 8, 20); step();
    set_k(0, 1, 8, 20); step();
    chk("t1 pending", st0[31:0], 32'h1);
    step();
    chk("t1 start pulse", ks0, 4'b0001);
    chk("t1 row", row0[31:0], 32'd8);
    chk("t1 nnz", nnz0[31:0], 32'd20);
    chk("t1 running", st0[31:0], 32'h2);
    repeat (5) step();
    kdone[0] = 1'b1; step(); kdone[0] = 1'b0;
    chk("t1 done status", st0[31:0], 32'h00000504);

    // 2: bad params then clear
    phase = "t2";
    set_k(1, 0, 0, 7); step();
    set_k(1, 1, 0, 7); step();
    chk("t2 err_param", st0[63:32], 32'h08);
    step();
    chk("t2 no start", ks0, '0);
    set_k(1, 3, 0, 7); step();
    chk("t2 cleared", st0[63:32], 32'h0);

    // 3: concurrency cap
    phase = "t3";
    do_reset();
    for (int k = 0; k < NK; k++) set_k(k, 0, k + 1, 2 * k + 3);
    step();
    for (int k = 0; k < NK; k++) set_k(k, 1, k + 1, 2 * k + 3);
    step();
    chk("t3 all pending", st0, {4{32'h1}});
    step(); chk("t3 start k0", ks0, 4'b0001);
    step(); chk("t3 start k1", ks0, 4'b0010);
    step(); chk("t3 no third", ks0, 4'b0000);
    chk("t3 k2 pending", st0[95:64], 32'h1);
    step(); step();
    kdone[0] = 1'b1; step(); kdone[0] = 1'b0;
    chk("t3 k0 done", st0[2], 1'b1);
    chk("t3 no start on done", ks0, 4'b0000);
    step();
    chk("t3 start k2", ks0, 4'b0100);
    chk("t3 k3 pending", st0[127:96], 32'h1);

    // 4: timeout
    phase = "t4";
    do_reset();
    set_k(2, 0, 5, 6); step();
    set_k(2, 1, 5, 6); step(); step();
    chk("t4 start k2", ks0, 4'b0100);
    repeat (15) step();
    chk("t4 still running", st0[95:64], 32'h00000F02);
    step();
    chk("t4 timeout", st0[95:64], 32'h00001014);
    kdone[2] = 1'b1; step(); kdone[2] = 1'b0;
    chk("t4 late done", st0[95:64], 32'h00001014);

    // 5: fairness on the single-slot instance
    phase = "t5";
    do_reset();
    for (int k = 0; k < NK; k++) set_k(k, 0, 3, 3);
    step();
    for (int cyc = 0; cyc < 300 && grants.size() < 6; cyc++) begin
      kdone = '0;
      for (int k = 0; k < 2; k++) begin
        if (m_run[1][k] && !m_first[1][k] && m_cnt[1][k] >= 2) kdone[k] = 1'b1;
        if (!m_run[1][k] && !m_pend[1][k]) cfg[96*k] = ~cfg[96*k];
      end
      step();
      for (int k = 0; k < 2; k++) if (ks1[k]) grants.push_back(k);
    end
    kdone = '0;
    chk("t5 grant count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) chk($sformatf("t5 grant %0d", i), grants[i], i % 2);

    // 6: reset during run
    phase = "t6";
    do_reset();
    set_k(3, 0, 9, 9); step();
    set_k(3, 1, 9, 9); step(); step();
    chk("t6 start k3", ks0, 4'b1000);
    repeat (3) step();
    areset = 1'b1; step();
    chk("t6 reset start", ks0, '0);
    chk("t6 reset status", st0, '0);
    chk("t6 reset row", row0, '0);
    chk("t6 reset nnz", nnz0, '0);
    areset = 1'b0;
    kdone[3] = 1'b1; step(); kdone[3] = 1'b0;
    repeat (4) step();
    chk("t6 held level", st0[127:96], 32'h0);
    set_k(3, 0, 9, 9); step();
    set_k(3, 1, 9, 9); step();
    chk("t6 restart pend", st0[127:96], 32'h1);
    step();
    chk("t6 restart start", ks0, 4'b1000);

    // random traffic against the model
    phase = "rand";
    do_reset();
    repeat (3000) begin
      for (int k = 0; k < NK; k++) begin
        c = cfg[96*k +: 32];
        if ($urandom_range(0, 7) == 0) c[0] = ~c[0];
        if ($urandom_range(0, 15) == 0) c[1] = ~c[1];
        if ($urandom_range(0, 31) == 0) c[31:2] = 30'($urandom);
        cfg[96*k +: 32] = c;
        if ($urandom_range(0, 5) == 0)
          cfg[96*k + 32 +: 32] = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
        if ($urandom_range(0, 5) == 0)
          cfg[96*k + 64 +: 32] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        kdone[k] = ($urandom_range(0, 9) == 0);
      end
      areset = ($urandom_range(0, 249) == 0);
      step();
    end
    areset = 1'b0;
    kdone  = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
